// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite register-bus responder.
package axi_lite_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    RD_ACC,
    WR_RSP,
    RD_RSP
  } regslv_state_e;
endpackage

// File: rtl/axi_lite_hold_buf.sv
// One-entry holding register; ready is registered and reflects the next-cycle empty state.
module axi_lite_hold_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             ready,
  output logic [WIDTH-1:0] dout
);
  logic full_nxt;

  always_comb begin
    full_nxt = full;
    if (clear) full_nxt = 1'b0;
    if (load)  full_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      ready <= 1'b0;
      dout  <= '0;
    end else begin
      full  <= full_nxt;
      ready <= !full_nxt;
      if (load) dout <= din;
    end
  end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave port terminated onto a single req/ack CSR bus, with read/write
// arbitration, access timeout and SLVERR reporting.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int REG_AW      = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [AW-1:0]     s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DW-1:0]     s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              reg_req,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DW-1:0]     reg_wdata,
  output logic [DW/8-1:0]   reg_wstrb,
  input  logic              reg_ack,
  input  logic              reg_err,
  input  logic [DW-1:0]     reg_rdata
);
  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  regslv_state_e     state, state_nxt;
  logic              aw_load, w_load, ar_load;
  logic              aw_full, w_full, ar_full;
  logic              wr_done, rd_done;
  logic              wr_rdy, rd_rdy, tie, tmo, prio_rd;
  logic [REG_AW-1:0] aw_word, ar_word;
  logic [DW+SW-1:0]  w_buf;
  logic [CW-1:0]     cnt;
  axi_resp_t         bresp_q, rresp_q;
  logic [DW-1:0]     rdata_q;
  logic              unused_addr;

  // The crossbar already decoded the window; only the word index matters here.
  assign unused_addr = ^{s_axi_awaddr[AW-1:REG_AW+2], s_axi_awaddr[1:0],
                         s_axi_araddr[AW-1:REG_AW+2], s_axi_araddr[1:0]};

  assign aw_load = s_axi_awvalid & s_axi_awready;
  assign w_load  = s_axi_wvalid  & s_axi_wready;
  assign ar_load = s_axi_arvalid & s_axi_arready;
  assign wr_done = (state == WR_RSP) & s_axi_bready;
  assign rd_done = (state == RD_RSP) & s_axi_rready;

  axi_lite_hold_buf #(.WIDTH(REG_AW)) u_aw_buf (
    .clk(ACLK), .rst_n(ARESETn), .load(aw_load), .clear(wr_done),
    .din(s_axi_awaddr[REG_AW+1:2]), .full(aw_full), .ready(s_axi_awready), .dout(aw_word)
  );

  axi_lite_hold_buf #(.WIDTH(DW+SW)) u_w_buf (
    .clk(ACLK), .rst_n(ARESETn), .load(w_load), .clear(wr_done),
    .din({s_axi_wstrb, s_axi_wdata}), .full(w_full), .ready(s_axi_wready), .dout(w_buf)
  );

  axi_lite_hold_buf #(.WIDTH(REG_AW)) u_ar_buf (
    .clk(ACLK), .rst_n(ARESETn), .load(ar_load), .clear(rd_done),
    .din(s_axi_araddr[REG_AW+1:2]), .full(ar_full), .ready(s_axi_arready), .dout(ar_word)
  );

  // Loads are looked through so an access starts the cycle after its handshake.
  assign wr_rdy = (aw_full | aw_load) & (w_full | w_load);
  assign rd_rdy = ar_full | ar_load;
  assign tie    = wr_rdy & rd_rdy;
  assign tmo    = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_rdy && (!rd_rdy || !prio_rd)) state_nxt = WR_ACC;
        else if (rd_rdy)                     state_nxt = RD_ACC;
      end
      WR_ACC:  if (reg_ack || tmo) state_nxt = WR_RSP;
      RD_ACC:  if (reg_ack || tmo) state_nxt = RD_RSP;
      WR_RSP:  if (s_axi_bready)   state_nxt = IDLE;
      RD_RSP:  if (s_axi_rready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reg_req      = 1'b0;
    reg_we       = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_rvalid = 1'b0;
    case (state)
      WR_ACC: begin
        reg_req = 1'b1;
        reg_we  = 1'b1;
      end
      RD_ACC:  reg_req      = 1'b1;
      WR_RSP:  s_axi_bvalid = 1'b1;
      RD_RSP:  s_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  assign reg_addr    = reg_we ? aw_word : ar_word;
  assign reg_wdata   = reg_we ? w_buf[DW-1:0] : '0;
  assign reg_wstrb   = reg_we ? w_buf[DW+SW-1:DW] : '0;
  assign s_axi_bresp = bresp_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rdata = rdata_q;

  // Response registers only change when an access completes, so they stay
  // stable through the whole VALID phase and between transactions.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt     <= '0;
      prio_rd <= 1'b0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      cnt <= reg_req ? cnt + 1'b1 : '0;
      if (state == IDLE && tie) prio_rd <= ~prio_rd;
      if (state == WR_ACC) begin
        if (reg_ack)  bresp_q <= reg_err ? RESP_SLVERR : RESP_OKAY;
        else if (tmo) bresp_q <= RESP_SLVERR;
      end
      if (state == RD_ACC) begin
        if (reg_ack) begin
          rresp_q <= reg_err ? RESP_SLVERR : RESP_OKAY;
          rdata_q <= reg_rdata;
        end else if (tmo) begin
          rresp_q <= RESP_SLVERR;
          rdata_q <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed + randomized bench: a CSR responder model behind the DUT and a word-array
// reference of what each AXI read must return.
module tb_axi_lite_reg_slave;
  localparam int REG_AW = 10;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        reg_req, reg_we;
  logic [REG_AW-1:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack = 1'b0, reg_err = 1'b0;
  logic [31:0] reg_rdata = '0;

  always #5 clk = ~clk;

  axi_lite_reg_slave #(.AW(32), .DW(32), .REG_AW(REG_AW), .TIMEOUT_CYC(TMO)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // CSR responder: words with addr[9:8]==3 answer with an error.
  logic [31:0] resp_mem [1024];
  int rsp_delay = 0, wait_cnt = 0, bad_strb = 0;
  bit rsp_never = 1'b0, force_ack = 1'b0;

  always @(negedge clk) begin
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    if (force_ack) reg_ack = 1'b1;
    else if (!reg_req) wait_cnt = 0;
    else if (!rsp_never && wait_cnt == rsp_delay) begin
      reg_ack = 1'b1; wait_cnt = 0;
      reg_err = (reg_addr[9:8] == 2'b11);
      if (reg_we) begin
        if (!reg_err)
          for (int b = 0; b < 4; b++)
            if (reg_wstrb[b]) resp_mem[reg_addr][b*8 +: 8] = reg_wdata[b*8 +: 8];
      end else begin
        reg_rdata = reg_err ? {16'hDEAD, 6'h0, reg_addr} : resp_mem[reg_addr];
        if (reg_wstrb != 4'h0) bad_strb++;
      end
    end else wait_cnt++;
  end

  int b_cnt = 0, r_cnt = 0;
  bit acc_q[$];
  logic req_d = 1'b0;
  always @(negedge clk) begin
    if (bvalid && bready) b_cnt++;
    if (rvalid && rready) r_cnt++;
    if (reg_req && !req_d) acc_q.push_back(reg_we);
    req_d = reg_req;
  end

  // Reference: what a read of each word must return.
  logic [31:0] model_mem [1024];

  function automatic bit is_err(input logic [9:0] w);
    return w[9:8] == 2'b11;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [9:0] w);
    return is_err(w) ? (32'hDEAD_0000 | {22'h0, w}) : model_mem[w];
  endfunction

  task automatic model_wr(input logic [9:0] w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (!is_err(w)) model_mem[w] = (model_mem[w] & ~m) | (d & m);
  endtask

  function automatic logic [31:0] rand_addr(input logic [9:0] w);
    logic [31:0] r;
    r = $urandom();
    r[11:2] = w;
    return r;
  endfunction

  function automatic logic [9:0] rand_word();
    if ($urandom_range(0, 5) == 0) return 10'h300 | 10'($urandom_range(0, 3));
    return 10'($urandom_range(0, 15));
  endfunction

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int bdly, output logic [1:0] resp);
    bit aw_done, w_done, got;
    int n;
    aw_done = 0; w_done = 0; got = 0; n = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 100) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_accept", 32'(aw_done & w_done), 1);
    repeat (bdly) @(posedge clk);
    #1 bready = 1'b1;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (bvalid) begin got = 1; resp = bresp; end
      @(posedge clk); #1;
      n++;
    end
    bready = 1'b0;
    chk("wr_b_seen", 32'(got), 1);
  endtask

  task automatic axi_rd(input logic [31:0] a, input int rdly,
                        output logic [31:0] d, output logic [1:0] resp);
    bit ar_done, got;
    int n;
    ar_done = 0; got = 0; n = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1'b1;
    while (!ar_done && n < 100) begin
      @(negedge clk);
      if (arvalid && arready) ar_done = 1;
      @(posedge clk); #1;
      if (ar_done) arvalid = 1'b0;
      n++;
    end
    arvalid = 1'b0;
    chk("rd_accept", 32'(ar_done), 1);
    repeat (rdly) @(posedge clk);
    #1 rready = 1'b1;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (rvalid) begin got = 1; d = rdata; resp = rresp; end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    chk("rd_r_seen", 32'(got), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r1, r2;
    logic [31:0] d1, d2, rd, er;
    logic [9:0]  w1, w2;
    logic [3:0]  s1;
    int n, b0, r0, kind;

    for (int i = 0; i < 1024; i++) begin resp_mem[i] = '0; model_mem[i] = '0; end

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_req", 32'(reg_req), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'({awready, wready, arready}), 3'b111);

    // 1: AW+W together, zero-wait ack
    rsp_delay = 0;
    awaddr = 32'h4000_0008; wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_req", 32'(reg_req), 1);
    chk("t1_we", 32'(reg_we), 1);
    chk("t1_addr", 32'(reg_addr), 2);
    chk("t1_wdata", reg_wdata, 32'hA5A5_5A5A);
    chk("t1_wstrb", 32'(reg_wstrb), 4'hF);
    @(posedge clk); #1;
    chk("t1_req_one_cycle", 32'(reg_req), 0);
    chk("t1_bvalid", 32'(bvalid), 1);
    chk("t1_bresp", 32'(bresp), 0);
    bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    chk("t1_bvalid_clr", 32'(bvalid), 0);
    model_wr(10'd2, 32'hA5A5_5A5A, 4'hF);

    // 2: W three cycles ahead of AW
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    chk("t2_wready_drop", 32'(wready), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t2_no_req", 32'(reg_req), 0);
    end
    awaddr = 32'h0000_0004; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    chk("t2_req", 32'(reg_req), 1);
    chk("t2_addr", 32'(reg_addr), 1);
    chk("t2_wdata", reg_wdata, 32'h0BAD_F00D);
    @(posedge clk); #1;
    chk("t2_bvalid", 32'(bvalid), 1);
    bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    model_wr(10'd1, 32'h0BAD_F00D, 4'hF);

    // 3: slow read with R back-pressure
    resp_mem[3] = 32'h1234_5678; model_mem[3] = 32'h1234_5678; rsp_delay = 5;
    araddr = 32'h0000_000C; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    chk("t3_arready_drop", 32'(arready), 0);
    n = 0;
    while (reg_req && n < 50) begin
      chk("t3_rvalid_early", 32'(rvalid), 0);
      n++;
      @(posedge clk); #1;
    end
    chk("t3_req_cycles", n, 6);
    repeat (4) begin
      chk("t3_rvalid_hold", 32'(rvalid), 1);
      chk("t3_rdata_hold", rdata, 32'h1234_5678);
      chk("t3_rresp_hold", 32'(rresp), 0);
      chk("t3_arready_low", 32'(arready), 0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    chk("t3_rvalid_clr", 32'(rvalid), 0);
    chk("t3_arready_back", 32'(arready), 1);

    // 4: two ties in a row alternate the grant
    rsp_delay = 0; acc_q.delete();
    bready = 1'b1; rready = 1'b1;
    repeat (2) begin
      b0 = b_cnt; r0 = r_cnt; d1 = $urandom();
      awaddr = 32'h0000_0020; wdata = d1; wstrb = 4'hF; araddr = 32'h0000_0024;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      n = 0;
      while ((b_cnt == b0 || r_cnt == r0) && n < 50) begin @(posedge clk); #1; n++; end
      chk("t4_both_done", 32'(n < 50), 1);
      model_wr(10'd8, d1, 4'hF);
    end
    bready = 1'b0; rready = 1'b0;
    chk("t4_acc_count", acc_q.size(), 4);
    chk("t4_order", 32'({acc_q[0], acc_q[1], acc_q[2], acc_q[3]}), 4'b1001);

    // 5: responder silent -> timeout, late ack ignored
    rsp_never = 1'b1; r0 = r_cnt;
    araddr = 32'h0000_0010; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    n = 0;
    while (reg_req && n < 100) begin n++; @(posedge clk); #1; end
    chk("t5_req_cycles", n, TMO);
    chk("t5_rvalid", 32'(rvalid), 1);
    chk("t5_rresp", 32'(rresp), 2);
    chk("t5_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    chk("t5_rresp_after_late_ack", 32'(rresp), 2);
    chk("t5_rdata_after_late_ack", rdata, 0);
    rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("t5_single_r", r_cnt - r0, 1);
    chk("t5_no_req", 32'(reg_req), 0);
    chk("t5_rvalid_clr", 32'(rvalid), 0);

    // 6: reset in the middle of a write access
    b0 = b_cnt; bready = 1'b1;
    awaddr = 32'h0000_0030; wdata = 32'h7777_7777; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    chk("t6_req", 32'(reg_req), 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t6_req_drop", 32'(reg_req), 0);
    chk("t6_bvalid_drop", 32'(bvalid), 0);
    chk("t6_readys_drop", 32'({awready, wready, arready}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; rsp_never = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("t6_no_stray_b", b_cnt - b0, 0);
    bready = 1'b0;
    axi_wr(32'h0000_0034, 32'hCAFE_BABE, 4'hF, 0, r1);
    chk("t6_fresh_bresp", 32'(r1), 0);
    model_wr(10'd13, 32'hCAFE_BABE, 4'hF);

    // Randomized traffic against the word model
    for (int it = 0; it < 48; it++) begin
      kind = $urandom_range(0, 2);
      rsp_delay = $urandom_range(0, 3);
      w1 = rand_word(); d1 = $urandom(); s1 = 4'($urandom_range(0, 15));
      if (kind == 0) begin
        axi_wr(rand_addr(w1), d1, s1, $urandom_range(0, 2), r1);
        chk("rnd_bresp", 32'(r1), is_err(w1) ? 2 : 0);
        model_wr(w1, d1, s1);
      end else if (kind == 1) begin
        er = exp_rd(w1);
        axi_rd(rand_addr(w1), $urandom_range(0, 2), rd, r2);
        chk("rnd_rdata", rd, er);
        chk("rnd_rresp", 32'(r2), is_err(w1) ? 2 : 0);
      end else begin
        w2 = w1 ^ 10'h1; er = exp_rd(w2);
        fork
          axi_wr(rand_addr(w1), d1, s1, $urandom_range(0, 2), r1);
          axi_rd(rand_addr(w2), $urandom_range(0, 2), d2, r2);
        join
        chk("rnd_pair_bresp", 32'(r1), is_err(w1) ? 2 : 0);
        chk("rnd_pair_rdata", d2, er);
        chk("rnd_pair_rresp", 32'(r2), is_err(w2) ? 2 : 0);
        model_wr(w1, d1, s1);
      end
    end

    // Read back the whole low window
    rsp_delay = 1;
    for (int w = 0; w < 16; w++) begin
      er = exp_rd(10'(w));
      axi_rd(32'(w) << 2, 0, rd, r2);
      chk("sweep_rdata", rd, er);
      chk("sweep_rresp", 32'(r2), 0);
    end
    chk("read_wstrb_zero", bad_strb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
